sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
// - Shares the single wide SRAM port between NUM_REQ masters: layer rasterizer, texture fetch and alpha blender.
// - Grants one whole access at a time, round-robin, so each master keeps its own READ/WAIT sequencing.
// - Drives the SRAM read_enable/write_enable/address/write_data bus and returns read_data and a done strobe.
// PARAMETERS
// - NUM_REQ      3            number of requesters; index 0 = rasterizer, 1 = texture, 2 = alpha blend
// - ADDR_W       24           SRAM address width
// - DATA_W       1536         SRAM word-burst width (3 bytes x 64 words x 8)
// - ACCESS_CYC   2            cycles the SRAM enables are held per access; legal range 1..15
// - ADDR_LIMIT   24'd208896   first illegal address (end of output buffer)
// PORTS
// - clk          in   1                 clock
// - n_rst        in   1                 asynchronous active-low reset
// - req          in   NUM_REQ           access request per master; hold high until ack
// - req_wr       in   NUM_REQ           1 = write, 0 = read; sampled with req
// - req_addr     in   NUM_REQ*ADDR_W    packed addresses; master i at [i*ADDR_W +: ADDR_W]
// - req_wdata    in   NUM_REQ*DATA_W    packed write data; master i at [i*DATA_W +: DATA_W]
// - ack          out  NUM_REQ           one-cycle done strobe to the granted master
// - rdata        out  DATA_W            read data; valid only while ack is high for a read
// - err          out  NUM_REQ           out-of-range strobe; see CONFIGURATION
// - busy         out  1                 high in every state except IDLE
// - sram_re      out  1                 SRAM read_enable
// - sram_we      out  1                 SRAM write_enable
// - sram_addr    out  ADDR_W            SRAM address
// - sram_wdata   out  DATA_W            SRAM write_data
// - sram_rdata   in   DATA_W            SRAM read_data; valid the cycle after the last enable cycle
// BEHAVIOUR
// - FSM states: IDLE, ACCESS, RESP.
// - Registers: state, grant index g, latched op/addr/wdata, cycle counter cnt, round-robin pointer last.
// - Reset values: state=IDLE, last=NUM_REQ-1, cnt=0, latches=0.
// - Outputs are decoded combinationally from state: all sram_*, ack, err and busy are 0 during and after reset.
// - IDLE -> ACCESS: any req high. Pick the first set bit searching last+1, last+2, ... modulo NUM_REQ.
//   - Latch g, req_wr[g], req_addr[g] and req_wdata[g]; set last=g, cnt=0.
// - ACCESS: sram_addr = latched addr; sram_re = !op or sram_we = op; sram_wdata = latched wdata.
//   - Hold for exactly ACCESS_CYC cycles: cnt increments each cycle; at cnt==ACCESS_CYC-1 go to RESP.
// - RESP (one cycle): enables low; ack[g]=1; rdata = sram_rdata (pass-through); -> IDLE.
// - Minimum request-to-ack latency is ACCESS_CYC+1 cycles; the next grant is evaluated in the following IDLE cycle.
// - Inputs are latched at grant; changes to a master's req_addr/req_wdata/req_wr after grant are ignored.
// - A master drops req in the cycle after ack. If req is still high in IDLE, it re-arbitrates like any new request.
// - req deasserted mid-access: the access still completes and ack still pulses.
// - Simultaneous requests: round-robin only, so no master waits more than NUM_REQ-1 accesses.
// - rdata is 0 whenever state != RESP or the access was a write.
// - Reset asserted mid-access: the FSM goes to IDLE at once; the aborted access gets no ack.
// CONFIGURATION
// - SRAM_ARB_BOUNDS_CHECK_EN defined: at grant, latched addr >= ADDR_LIMIT skips ACCESS and goes straight to RESP.
//   - In that RESP cycle ack[g]=1 and err[g]=1, with no SRAM enable.
// - Undefined: no range check is made; err is tied to 0 and every request is forwarded to the SRAM.
// TESTING
// - Master 2 reads 24'd65536; the SRAM model returns 'hABC after ACCESS_CYC=2
//   -> sram_re high cycles 1-2, ack[2] and rdata='hABC in cycle 3.
// - req=3'b111 held, each master dropping req after its ack -> grant order 0,1,2; reissued -> 0,1,2 again.
// - Master 0 writes addr 24'd143360 with data 'h5A.. -> sram_we high 2 cycles, sram_addr/sram_wdata match, ack[0].
// - Master 1 changes req_addr during ACCESS -> sram_addr stays at the granted value.
// - With SRAM_ARB_BOUNDS_CHECK_EN, read at 24'd208896 -> ack[1]=err[1]=1 in cycle 1, sram_re never high.
// - Assert n_rst in the first ACCESS cycle -> sram_re/ack drop at once; after release last=NUM_REQ-1, master 0 wins.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin arbiter granting whole SRAM accesses to NUM_REQ masters.
// Optional range check enabled by defining SRAM_ARB_BOUNDS_CHECK_EN.
module sram_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 1536,
  parameter int ACCESS_CYC = 2,
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = 24'd208896
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           rdata,
  output logic [NUM_REQ-1:0]          err,
  output logic                        busy,
  output logic                        sram_re,
  output logic                        sram_we,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic [DATA_W-1:0]           sram_wdata,
  input  logic [DATA_W-1:0]           sram_rdata
);
  localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic [GW-1:0] g, last, pick;
  logic found, op, oob, bad, check_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0] cnt;
  // first requester found searching last+1, last+2, ... modulo NUM_REQ
  always_comb begin
    pick = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(last) + k) % NUM_REQ]) begin
        pick = GW'((int'(last) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end
  assign bad = check_en && (req_addr[pick*ADDR_W +: ADDR_W] >= ADDR_LIMIT);
  // grant latching, access timing and single-cycle response
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      g <= '0;
      last <= GW'(NUM_REQ - 1);
      op <= 1'b0;
      oob <= 1'b0;
      addr <= '0;
      wdata <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          g <= pick;
          last <= pick;
          op <= req_wr[pick];
          addr <= req_addr[pick*ADDR_W +: ADDR_W];
          wdata <= req_wdata[pick*DATA_W +: DATA_W];
          oob <= bad;
          cnt <= '0;
          state <= bad ? RESP : ACCESS;
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          state <= (cnt == 4'(ACCESS_CYC - 1)) ? RESP : ACCESS;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign busy = state != IDLE;
  assign sram_re = state == ACCESS && !op;
  assign sram_we = state == ACCESS && op;
  assign sram_addr = state == ACCESS ? addr : '0;
  assign sram_wdata = state == ACCESS ? wdata : '0;
  assign ack = state == RESP ? NUM_REQ'(1) << g : '0;
  assign rdata = (state == RESP && !op && !oob) ? sram_rdata : '0;
`ifdef SRAM_ARB_BOUNDS_CHECK_EN
  assign check_en = 1'b1;
  assign err = (state == RESP && oob) ? NUM_REQ'(1) << g : '0;
`else
  assign check_en = 1'b0;
  assign err = '0;
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: randomized scoreboard bench with a transaction-level round-robin model and SRAM model.
module tb_sram_port_arbiter;
  localparam int N = 3;
  localparam int AW = 24;
  localparam int DW = 1536;
  localparam int AC = 2;
  localparam logic [AW-1:0] LIM = 24'd208896;
`ifdef SRAM_ARB_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  typedef struct {
    int m;
    bit op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit oob;
  } txn_t;

  logic clk, n_rst;
  logic [N-1:0] req, req_wr, ack, err;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rdata, sram_wdata, sram_rdata;
  logic busy, sram_re, sram_we;
  logic [AW-1:0] sram_addr;

  txn_t exp_q[$];
  logic [DW-1:0] sram_mem [logic [AW-1:0]];
  logic [DW-1:0] mdl_mem [logic [AW-1:0]];
  int checks = 0, fails = 0, cyc = 0, acc_cnt = 0, last_m;

  sram_port_arbiter dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .sram_re(sram_re), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {64{a}};
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    return r < 8 ? AW'(r) << 12 : LIM + AW'($urandom_range(0, 3));
  endfunction

  // SRAM: writes land at the clock edge, read data appears the cycle after the enable
  initial sram_rdata = '0;
  always @(posedge clk) begin
    if (sram_we) sram_mem[sram_addr] = sram_wdata;
    if (sram_re) sram_rdata <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : pat(sram_addr);
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic issue(input int m, input bit op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wr[m] = op;
    req_addr[m*AW +: AW] = a;
    req_wdata[m*DW +: DW] = d;
  endtask

  task automatic push(input int m);
    txn_t t;
    t.m = m;
    t.op = req_wr[m];
    t.addr = req_addr[m*AW +: AW];
    t.wdata = req_wdata[m*DW +: DW];
    t.oob = BC && t.addr >= LIM;
    t.rdata = (t.op || t.oob) ? '0 : (mdl_mem.exists(t.addr) ? mdl_mem[t.addr] : pat(t.addr));
    if (t.op && !t.oob) mdl_mem[t.addr] = t.wdata;
    exp_q.push_back(t);
  endtask

  // model predicts the service order, then masters hold req until their own ack
  task automatic run_round(input logic [N-1:0] mask, input int exp_lat);
    int p, n, c0;
    bit seen;
    @(negedge clk);
    p = last_m;
    for (int k = 0; k < N; k++) begin
      p = (p + 1) % N;
      if (mask[p]) begin
        push(p);
        last_m = p;
      end
    end
    req = mask;
    c0 = cyc;
    n = 0;
    seen = 1'b0;
    while (req != '0 && n < 200) begin
      @(negedge clk);
      n++;
      if ((sram_re || sram_we) && exp_q.size() > 0)
        issue(exp_q[0].m, ~req_wr[exp_q[0].m], rnd_addr(), rnd_data());
      for (int i = 0; i < N; i++) begin
        if (ack[i] && req[i]) begin
          if (exp_lat > 0 && !seen) check("latency", DW'(cyc - c0), DW'(exp_lat));
          seen = 1'b1;
          req[i] = 1'b0;
        end
      end
    end
    if (req != '0) begin
      check("round_timeout", DW'(req), '0);
      req = '0;
    end
  endtask

  // monitor: compare every SRAM access and every ack against the head of the scoreboard
  initial begin
    txn_t t;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (!n_rst) acc_cnt = 0;
      else begin
        if (sram_re || sram_we) begin
          if (exp_q.size() == 0) check("unexpected_access", 1, 0);
          else begin
            t = exp_q[0];
            check("sram_we", DW'(sram_we), DW'(t.op && !t.oob));
            check("sram_re", DW'(sram_re), DW'(!t.op && !t.oob));
            check("sram_addr", DW'(sram_addr), DW'(t.addr));
            check("sram_wdata", sram_wdata, t.wdata);
            acc_cnt++;
          end
        end
        if (ack != '0) begin
          if (exp_q.size() == 0) check("unexpected_ack", DW'(ack), '0);
          else begin
            t = exp_q.pop_front();
            oh = N'(1) << t.m;
            check("ack", DW'(ack), DW'(oh));
            check("err", DW'(err), t.oob ? DW'(oh) : '0);
            check("rdata", rdata, t.rdata);
            check("access_cycles", DW'(acc_cnt), t.oob ? '0 : DW'(AC));
            acc_cnt = 0;
          end
        end else begin
          check("idle_rdata", rdata, '0);
          check("idle_err", DW'(err), '0);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] mask;
    int n;
    n_rst = 1'b0;
    req = '0;
    req_wr = '0;
    req_addr = '0;
    req_wdata = '0;
    last_m = N - 1;
    repeat (3) @(negedge clk);
    check("rst_busy", DW'(busy), '0);
    check("rst_re", DW'(sram_re), '0);
    check("rst_we", DW'(sram_we), '0);
    check("rst_ack", DW'(ack), '0);
    check("rst_err", DW'(err), '0);
    check("rst_rdata", rdata, '0);
    check("rst_addr", DW'(sram_addr), '0);
    n_rst = 1'b1;
    issue(2, 1'b0, 24'd65536, rnd_data());
    run_round(3'b100, AC + 1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) issue(i, 1'($urandom), rnd_addr(), rnd_data());
      run_round(3'b111, 0);
    end
    issue(0, 1'b1, 24'd143360, {192{8'h5A}});
    run_round(3'b001, AC + 1);
    issue(1, 1'b0, 24'd143360, rnd_data());
    run_round(3'b010, AC + 1);
    @(negedge clk);
    issue(1, 1'b0, 24'd4096, rnd_data());
    push(1);
    req = 3'b010;
    n = 0;
    while (!sram_re && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_access", DW'(sram_re), DW'(1));
    n_rst = 1'b0;
    #1;
    check("abort_re", DW'(sram_re), '0);
    check("abort_ack", DW'(ack), '0);
    check("abort_busy", DW'(busy), '0);
    req = '0;
    exp_q.delete();
    last_m = N - 1;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < N; i++) issue(i, 1'b0, AW'(i) << 12, rnd_data());
    run_round(3'b111, 0);
    repeat (80) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) if (mask[i]) issue(i, 1'($urandom), rnd_addr(), rnd_data());
      run_round(mask, 0);
    end
    repeat (4) @(negedge clk);
    check("queue_drained", DW'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
